// File: rtl/uart_tx_fifo_reader_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_fifo_reader_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned TICK_IDX_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd4
  } state_e;
`endif

  // Oversample tick period in system clocks, integer-truncated.
  function automatic int unsigned tick_period(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_reader_baud_tick_gen.sv
// Free-running oversample tick generator: counts 0..PERIOD-1 and flags the last count.
module baud_tick_gen #(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == CntLast)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from an upstream FIFO and sends 8N1 frames
// (8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_fifo_reader
  import uart_tx_fifo_reader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_pop_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned TickPeriod = tick_period(CLK_FREQ, BAUD);
  localparam logic [TICK_IDX_W-1:0] TickLast = TICK_IDX_W'(OVERSAMPLE - 1);
  localparam logic [BIT_IDX_W-1:0]  BitLast  = BIT_IDX_W'(DATA_BITS - 1);

  state_e                state_q, state_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [BIT_IDX_W-1:0]  bit_q, bit_d;
  logic [TICK_IDX_W-1:0] tcnt_q, tcnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic tick;
  logic bit_end;
  logic pop;

  baud_tick_gen #(
    .PERIOD (TickPeriod)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (pop),
    .tick  (tick)
  );

  // A bit ends on the 16th oversample tick.
  assign bit_end = tick && (tcnt_q == TickLast);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    if (state_q != StIdle && tick) begin
      tcnt_d = tcnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        tcnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_pop_data;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == BitLast) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Line level is a registered function of the next state, so tx falls
    // exactly one cycle after the pop.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = ^shift_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      bit_q   <= '0;
      tcnt_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tcnt_q  <= tcnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Gate with rst so no byte is consumed while reset is held.
  assign fifo_pop = pop && !rst;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader: FIFO model plus byte scoreboard.
module tb_uart_tx_fifo_reader;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int BIT_CYC = 160;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * BIT_CYC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_pop_data;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  logic [7:0]  fifo_mem [0:63];
  int unsigned wr_cnt = 0;
  int unsigned rd_ptr = 0;
  logic        ovr_en = 1'b0;
  logic [7:0]  ovr_data = 8'h00;
  logic [7:0]  exp_q [$];

  int tests = 0;
  int fails = 0;

  uart_tx_fifo_reader #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_pop_data (fifo_pop_data),
    .fifo_pop      (fifo_pop),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty    = (rd_ptr == wr_cnt);
  assign fifo_pop_data = ovr_en ? ovr_data : fifo_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_pop === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_cnt[5:0]] = b;
    wr_cnt++;
    exp_q.push_back(b);
  endtask

  task automatic wait_start(output bit seen);
    int t;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 4000) begin
      if (tx === 1'b0) seen = 1'b1;
      else begin
        @(negedge clk);
        t++;
      end
    end
  endtask

  // Follows one frame from its start edge through the cycle after tx_done.
  task automatic recv_frame(input bit b2b);
    bit         seen;
    logic [7:0] exp_b;
    logic [7:0] got;
    logic [11:0] fv;
    int bad_tx, bad_busy, bad_done, bad_pop;
    wait_start(seen);
    check("start_edge", 32'(seen), 32'd1);
    if (!seen) return;
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
      return;
    end
    exp_b = exp_q.pop_front();
    fv = '1;
    fv[0] = 1'b0;
    fv[8:1] = exp_b;
`ifdef UART_TX_PARITY_EN
    fv[9] = ^exp_b;
`endif
    got = 8'h00;
    bad_tx = 0; bad_busy = 0; bad_done = 0; bad_pop = 0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (tx !== fv[c / BIT_CYC]) bad_tx++;
      if ((c % BIT_CYC) == BIT_CYC / 2 && (c / BIT_CYC) >= 1 && (c / BIT_CYC) <= 8)
        got[(c / BIT_CYC) - 1] = tx;
      if (tx_busy !== 1'b1) bad_busy++;
      if (tx_done !== 1'b0) bad_done++;
      if (fifo_pop !== 1'b0) bad_pop++;
      @(negedge clk);
    end
    check("frame_byte", 32'(got), 32'(exp_b));
    check("frame_bit_timing", 32'(bad_tx), 32'd0);
    check("busy_in_frame", 32'(bad_busy), 32'd0);
    check("done_early", 32'(bad_done), 32'd0);
    check("pop_outside_idle", 32'(bad_pop), 32'd0);
    check("done_at_end", 32'(tx_done), 32'd1);
    check("busy_idle_cycle", 32'(tx_busy), 32'd0);
    @(negedge clk);
    check("gap_next_start", 32'(tx), b2b ? 32'd0 : 32'd1);
    check("done_one_cycle", 32'(tx_done), 32'd0);
  endtask

  initial begin
    bit seen;
    int bad_tx, bad_pop, bad_busy;
    int unsigned base;

    for (int i = 0; i < 64; i++) fifo_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
    rst = 1'b0;

    // Idle line with an empty FIFO.
    bad_tx = 0; bad_pop = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (fifo_pop !== 1'b0) bad_pop++;
      if (tx_busy !== 1'b0) bad_busy++;
    end
    check("idle_tx", 32'(bad_tx), 32'd0);
    check("idle_pop", 32'(bad_pop), 32'd0);
    check("idle_busy", 32'(bad_busy), 32'd0);

    // Single byte.
    push(8'hA5);
    recv_frame(1'b0);
    check("pops_single", rd_ptr, 32'd1);

    // Full FIFO drained back-to-back.
    base = rd_ptr;
    push(8'h00); push(8'hFF); push(8'h55); push(8'h81);
    recv_frame(1'b1);
    recv_frame(1'b1);
    recv_frame(1'b1);
    check("fifo_empty_after_4th", 32'(fifo_empty), 32'd1);
    recv_frame(1'b0);
    check("pops_burst", rd_ptr - base, 32'd4);

    // FIFO data changes mid-frame must not affect the latched byte.
    push(8'hC3);
    wait_start(seen);
    ovr_data = 8'h3C;
    ovr_en   = 1'b1;
    recv_frame(1'b0);
    ovr_en   = 1'b0;

    // Abort mid-frame with an empty FIFO: no replay afterwards.
    push(8'h96);
    wait_start(seen);
    check("abort1_start", 32'(seen), 32'd1);
    void'(exp_q.pop_front());
    repeat (500) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort1_tx", 32'(tx), 32'd1);
    check("abort1_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad_tx = 0; bad_pop = 0; bad_busy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (fifo_pop !== 1'b0) bad_pop++;
      if (tx_busy !== 1'b0) bad_busy++;
    end
    check("no_replay_tx", 32'(bad_tx), 32'd0);
    check("no_replay_pop", 32'(bad_pop), 32'd0);
    check("no_replay_busy", 32'(bad_busy), 32'd0);

    // Abort with a byte waiting: no pop during reset, fresh frame after.
    push(8'h5A);
    wait_start(seen);
    check("abort2_start", 32'(seen), 32'd1);
    void'(exp_q.pop_front());
    repeat (500) @(negedge clk);
    rst = 1'b1;
    push(8'h3C);
    #1;
    check("abort2_tx", 32'(tx), 32'd1);
    check("abort2_busy", 32'(tx_busy), 32'd0);
    check("pop_in_reset", 32'(fifo_pop), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    recv_frame(1'b0);

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    recv_frame(1'b0);
`endif

    check("pops_total", rd_ptr, wr_cnt);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the serial line rate in bit/s.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: the empty flag of the upstream 4-entry byte FIFO.
REQ-006 The block SHALL have port fifo_pop_data, input, 8 bits: the FIFO head byte, combinationally valid whenever fifo_empty=0.
REQ-007 The block SHALL have port fifo_pop, output, 1 bit: a pop request to the FIFO, one cycle wide.
REQ-008 The block SHALL have port tx, output, 1 bit: the serial line, idle-high and registered.
REQ-009 The block SHALL have port tx_busy, output, 1 bit: high while any frame is in progress (state not IDLE).
REQ-010 The block SHALL have port tx_done, output, 1 bit: a one-cycle pulse at completion of a stop bit.

Function
REQ-011 The block SHALL derive tick period P = CLK_FREQ/(BAUD*16) cycles, integer-truncated; every bit SHALL last exactly 16 ticks, i.e. 16*P cycles.
REQ-012 The block SHALL implement the states IDLE, START, DATA, PARITY (only when the parity feature is compiled in), and STOP.
REQ-013 In IDLE with fifo_empty=0, the block SHALL drive fifo_pop=1 combinationally in that cycle, latch fifo_pop_data into a shift register on the same edge, clear the tick generator and tick counter, and move to START.
REQ-014 fifo_pop SHALL be 0 in every state other than IDLE, and SHALL be 0 whenever fifo_empty=1.
REQ-015 tx SHALL go low on the cycle after the pop cycle, giving a pop-to-start-edge latency of 1 cycle.
REQ-016 START SHALL drive tx=0 for 16 ticks.
REQ-017 DATA SHALL send 8 bits LSB first, each held for 16 ticks, under control of a 3-bit bit index that wraps 7->0 on exit.
REQ-018 STOP SHALL drive tx=1 for 16 ticks; on the 16th tick the block SHALL pulse tx_done for one cycle and return to IDLE.
REQ-019 Back-to-back bytes SHALL be separated by exactly one IDLE cycle, so the effective stop bit is 16*P+1 cycles, with no other gap.
REQ-020 fifo_pop_data and fifo_empty SHALL be ignored outside IDLE; the latched byte SHALL be immune to FIFO changes mid-frame.
REQ-021 tx_busy SHALL be 1 from the cycle after the pop through the last STOP cycle, inclusive.

Reset
REQ-022 On rst=1, the block SHALL asynchronously set state=IDLE, tx=1, tx_busy=0, tx_done=0, fifo_pop=0, shift register=0, bit index=0, and tick counters=0.
REQ-023 On reset mid-frame, the block SHALL abort the frame immediately, return tx high, not pop on the reset cycle, and not replay the aborted byte.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, the block SHALL insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the 8 data bits) for 16 ticks.
REQ-025 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and the frame SHALL be 8N1 (10 bits).

Structure
REQ-026 A shared package SHALL hold the state encoding (3-bit enumeration), the OVERSAMPLE=16 constant, and the DATA_BITS=8 constant.
REQ-027 The design SHALL contain sub-module baud_tick_gen (ports clk, rst, clear, tick; counts 0..P-1 and pulses tick one cycle at P-1; clear is synchronous).
REQ-028 The state machine SHALL use the registered-next style, with separate sequential and combinational processes.

Verification (CLK_FREQ=1_600_000, BAUD=10_000 -> P=10, bit=160 cycles)
REQ-029 Reset then hold fifo_empty=1 for 1000 cycles -> tx=1, fifo_pop=0, and tx_busy=0 throughout.
REQ-030 Present 0xA5 with empty deasserted -> one fifo_pop pulse; tx reads 0,1,0,1,0,0,1,0,1,1, each 160 cycles; tx_done pulses once at cycle 1600 after the start edge.
REQ-031 Queue 0x00, 0xFF, 0x55, 0x81 (FIFO full) -> exactly 4 pops, each frame correct, with exactly one IDLE cycle between frames, and FIFO empty after the 4th pop.
REQ-032 Change fifo_pop_data to 0x3C during the DATA bits of a 0xC3 frame -> the transmitted byte remains 0xC3.
REQ-033 Assert rst at cycle 500 of a frame -> tx=1 in the same cycle, tx_busy=0, and on release a fresh frame starts from the FIFO head only if fifo_empty=0.
REQ-034 With UART_TX_PARITY_EN defined, send 0x07 -> the parity bit is 1, the frame is 11 bits, and tx_done occurs at cycle 1760.
